// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One byte is accepted per frame; there is no holding buffer.
`timescale 1ns/1ps
module uart_tx #(
    parameter int BPS_PARA  = 625,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [12:0] BIT_LAST = 13'(BPS_PARA - 1);
    localparam logic        PAR_EN   = ((PARITY == 1) || (PARITY == 2)) ? 1'b1 : 1'b0;
    localparam logic        PAR_ODD  = (PARITY == 2) ? 1'b1 : 1'b0;
    localparam logic        STOP_TWO = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t      state_r, state_s;
    logic [12:0] timer_r, timer_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        par_r, par_s;
    logic        stop_cnt_r, stop_cnt_s;
    logic        tx_r, tx_s;
    logic        ready_r, ready_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        wrap_s;

    assign wrap_s   = (timer_r == BIT_LAST);
    assign tx       = tx_r;
    assign tx_ready = ready_r;
    assign tx_busy  = busy_r;
    assign tx_done  = done_r;

    // Next-state and next-output logic; tx is computed one edge ahead so the line is registered.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        par_s      = par_r;
        stop_cnt_s = stop_cnt_r;
        tx_s       = tx_r;
        ready_s    = ready_r;
        busy_s     = busy_r;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                timer_s = 13'd0;
                if (tx_valid && ready_r) begin
                    state_s    = ST_START;
                    shift_s    = tx_data;
                    par_s      = parity_bit(tx_data, PAR_ODD);
                    bit_idx_s  = 3'd0;
                    stop_cnt_s = 1'b0;
                    tx_s       = 1'b0;
                    busy_s     = 1'b1;
                    ready_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                    busy_s  = 1'b0;
                    ready_s = 1'b1;
                end
            end

            ST_START: begin
                if (wrap_s) begin
                    state_s   = ST_DATA;
                    timer_s   = 13'd0;
                    bit_idx_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    timer_s = timer_r + 13'd1;
                end
            end

            ST_DATA: begin
                if (wrap_s) begin
                    timer_s = 13'd0;
                    if (bit_idx_r == 3'd7) begin
                        if (PAR_EN) begin
                            state_s = ST_PARITY;
                            tx_s    = par_r;
                        end else begin
                            state_s    = ST_STOP;
                            stop_cnt_s = 1'b0;
                            tx_s       = 1'b1;
                        end
                    end else begin
                        // Shift out the next LSB; the index tracks how many bits have gone.
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    timer_s = timer_r + 13'd1;
                end
            end

            ST_PARITY: begin
                if (wrap_s) begin
                    state_s    = ST_STOP;
                    timer_s    = 13'd0;
                    stop_cnt_s = 1'b0;
                    tx_s       = 1'b1;
                end else begin
                    timer_s = timer_r + 13'd1;
                end
            end

            ST_STOP: begin
                if (wrap_s) begin
                    timer_s = 13'd0;
                    if (STOP_TWO && !stop_cnt_r) begin
                        stop_cnt_s = 1'b1;
                        tx_s       = 1'b1;
                    end else begin
                        state_s    = ST_IDLE;
                        stop_cnt_s = 1'b0;
                        tx_s       = 1'b1;
                        busy_s     = 1'b0;
                        ready_s    = 1'b1;
                        done_s     = 1'b1;
                    end
                end else begin
                    timer_s = timer_r + 13'd1;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                timer_s    = 13'd0;
                bit_idx_s  = 3'd0;
                stop_cnt_s = 1'b0;
                tx_s       = 1'b1;
                busy_s     = 1'b0;
                ready_s    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks the line high and aborts any frame without tx_done.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            timer_r    <= 13'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            par_r      <= 1'b0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            par_r      <= par_s;
            stop_cnt_r <= stop_cnt_s;
            tx_r       <= tx_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations, each shadowed by a queue-of-line-levels model,
// plus directed frames with hand-computed line patterns.
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_valid [4];
    logic [7:0] v_data  [4];
    logic       o_tx    [4];
    logic       o_rdy   [4];
    logic       o_busy  [4];
    logic       o_done  [4];
    int         d_vecs = 0;
    int         d_errs = 0;

    always #5 clk = ~clk;

    // Instance 0..2: 4 clocks/bit with parity none/even/odd; instance 3: 625 clocks/bit, 2 stop bits.
    for (genvar g = 0; g < 4; g++) begin : g_u
        localparam int BPS = (g == 3) ? 625 : 4;
        localparam int PAR = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int STP = (g == 3) ? 2 : 1;

        bit         m_tx   = 1'b1;
        bit         m_rdy  = 1'b0;
        bit         m_busy = 1'b0;
        bit         m_done = 1'b0;
        bit         lev_q[$];
        logic [7:0] cur;
        int         vecs = 0;
        int         errs = 0;

        uart_tx #(.BPS_PARA(BPS), .PARITY(PAR), .STOP_BITS(STP)) u_dut (
            .clk_in  (clk),
            .rst_in  (rst),
            .tx_data (v_data[g]),
            .tx_valid(v_valid[g]),
            .tx_ready(o_rdy[g]),
            .tx      (o_tx[g]),
            .tx_busy (o_busy[g]),
            .tx_done (o_done[g])
        );

        // Model: an accepted byte becomes a queue of per-clock line levels; an empty queue ends the frame.
        initial begin
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    lev_q.delete();
                    m_tx = 1'b1; m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
                end else begin
                    m_done = 1'b0;
                    if (m_busy) begin
                        if (lev_q.size() > 0) begin
                            m_tx = lev_q.pop_front();
                        end else begin
                            m_busy = 1'b0; m_done = 1'b1; m_rdy = 1'b1; m_tx = 1'b1;
                        end
                    end else if (m_rdy && v_valid[g]) begin
                        cur = v_data[g];
                        lev_q.delete();
                        repeat (BPS) lev_q.push_back(1'b0);
                        for (int i = 0; i < 8; i++) repeat (BPS) lev_q.push_back(cur[i]);
                        if (PAR != 0) repeat (BPS) lev_q.push_back((^cur) ^ (PAR == 2));
                        repeat (STP * BPS) lev_q.push_back(1'b1);
                        m_rdy = 1'b0; m_busy = 1'b1;
                        m_tx = lev_q.pop_front();
                    end else begin
                        m_rdy = 1'b1; m_tx = 1'b1;
                    end
                end
            end
        end

        initial begin
            repeat (2) @(negedge clk);
            forever begin
                @(negedge clk);
                vecs++;
                if (o_tx[g] !== m_tx || o_rdy[g] !== m_rdy || o_busy[g] !== m_busy || o_done[g] !== m_done) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL model_cmp u%0d t=%0t: tx,ready,busy,done got %b%b%b%b want %b%b%b%b",
                                 g, $time, o_tx[g], o_rdy[g], o_busy[g], o_done[g], m_tx, m_rdy, m_busy, m_done);
                end
            end
        end
    end

    function automatic logic [3:0] outs(input int k);
        return {o_tx[k], o_busy[k], o_done[k], o_rdy[k]};
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        d_vecs++;
        if (act !== exp) begin
            d_errs++;
            if (d_errs <= 30) $display("FAIL %s t=%0t: {tx,busy,done,ready} got %b want %b", nm, $time, act, exp);
        end
    endtask

    // Waits (bounded) for ready, presents one byte for one accept edge, then scrambles tx_data.
    task automatic launch(input int k, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!o_rdy[k] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!o_rdy[k]) chk("launch_timeout", outs(k), 4'b1001);
        v_data[k]  = d;
        v_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        v_valid[k] = 1'b0;
        v_data[k]  = 8'($urandom);
    endtask

    // Checks every clock of a frame against a literal list of levels (bit 0 = start bit).
    task automatic watch_frame(input int k, input string nm, input int bps, input int nlev, input logic [11:0] lev);
        for (int j = 0; j < nlev * bps; j++) begin
            @(negedge clk);
            chk(nm, outs(k), {lev[j / bps], 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        chk({nm, "_end"}, outs(k), 4'b1011);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_edge0", outs(0), 4'b1000);
        @(negedge clk);
        chk("rel_edge1", outs(0), 4'b1001);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            v_valid[k] = 1'b0;
            v_data[k]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("in_reset", outs(0), 4'b1000);
        release_rst();

        launch(0, 8'h55);
        watch_frame(0, "frame55", 4, 10, 12'b0010_1010_1010);

        launch(1, 8'h03);
        watch_frame(1, "even03", 4, 11, 12'b0100_0000_0110);
        launch(1, 8'h07);
        watch_frame(1, "even07", 4, 11, 12'b0110_0000_1110);
        launch(2, 8'h07);
        watch_frame(2, "odd07", 4, 11, 12'b0100_0000_1110);

        // Held tx_valid: second byte must start the cycle after tx_done.
        @(negedge clk);
        v_data[0]  = 8'hA5;
        v_valid[0] = 1'b1;
        @(posedge clk);
        #1 v_data[0] = 8'h3C;
        watch_frame(0, "b2b_a5", 4, 10, 12'b0011_0100_1010);
        @(posedge clk);
        #1 v_valid[0] = 1'b0;
        watch_frame(0, "b2b_3c", 4, 10, 12'b0010_0111_1000);

        // A tx_valid pulse while busy must be ignored.
        launch(0, 8'h0F);
        fork
            watch_frame(0, "ignore0f", 4, 10, 12'b0010_0001_1110);
            begin
                repeat (12) @(posedge clk);
                #1 v_valid[0] = 1'b1; v_data[0] = 8'hAA;
                @(posedge clk);
                #1 v_valid[0] = 1'b0;
            end
        join
        repeat (45) begin
            @(negedge clk);
            chk("no_second", outs(0), 4'b1001);
        end

        // Reset during data bit 3 aborts the frame.
        launch(0, 8'h00);
        repeat (18) @(negedge clk);
        chk("bit3_low", outs(0), 4'b0100);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("async_rst", outs(0), 4'b1000);
        repeat (3) begin
            @(negedge clk);
            chk("held_rst", outs(0), 4'b1000);
        end
        release_rst();
        launch(0, 8'hFF);
        watch_frame(0, "after_rst_ff", 4, 10, 12'b0011_1111_1110);

        launch(3, 8'h00);
        watch_frame(3, "stop2_625", 625, 11, 12'b0110_0000_0000);

        // Random traffic on all instances, with one reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            if (c == 700) rst = 1'b1;
            if (c == 703) rst = 1'b0;
            for (int k = 0; k < 4; k++) begin
                v_valid[k] = ($urandom_range(0, 3) == 0);
                v_data[k]  = 8'($urandom);
            end
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 d_vecs + g_u[0].vecs + g_u[1].vecs + g_u[2].vecs + g_u[3].vecs,
                 d_errs + g_u[0].errs + g_u[1].errs + g_u[2].errs + g_u[3].errs);
        $finish;
    end

endmodule
